ramb_read_arbiter: RTL and testbench

- Shares the single read port of one SB_RAM40_4K (ROM or RAM use) between NREQ requesters.
- Grants round-robin with a bounded burst per owner, drives the RAM read address and read enable, and returns read data tagged with a one-hot valid to the granted requester.
- Sits between requester logic and one SB_RAM40_4K instance; the RAM write port is not touched.

---
 rtl/ramb_read_arbiter_if.sv | 25 ++
 rtl/ramb_read_arbiter.sv | 113 +++++++++++
 tb/tb_ramb_read_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ramb_read_arbiter_if.sv
// rtl/ramb_read_arbiter_if.sv - requester and RAM read-port bundle for ramb_read_arbiter
interface ramb_read_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 11,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*AW-1:0] ADDR;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    RVALID;
    logic [DW-1:0]      RDATA_OUT;
    logic [AW-1:0]      RAM_RADDR;
    logic               RAM_RE;
    logic [DW-1:0]      RAM_RDATA;

    modport slave (
        input  REQ, ADDR, RAM_RDATA,
        output GNT, RVALID, RDATA_OUT, RAM_RADDR, RAM_RE
    );

    modport master (
        output REQ, ADDR, RAM_RDATA,
        input  GNT, RVALID, RDATA_OUT, RAM_RADDR, RAM_RE
    );
endinterface

// File: rtl/ramb_read_arbiter.sv
// rtl/ramb_read_arbiter.sv - round-robin burst arbiter for one SB_RAM40_4K read port
// Define RAMB_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module ramb_read_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 11,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic CLKIN,
    input  logic RESET,
    ramb_read_arbiter_if.slave bus
);
    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [1:0] LAST_REQ  = 2'(NREQ - 1);
    localparam logic [3:0] BURST_CNT = 4'(BURST);
    localparam logic [2:0] NREQ_W    = 3'(NREQ);

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] rvalid_q;
    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic            req_owner;
    logic            win_found;
    logic [1:0]      win_idx;

    always_comb begin
        req_owner = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 2'(i)) req_owner = bus.REQ[i];
        end
    end

    always_comb begin : arbitrate
        logic [2:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 3'd0;
`ifdef RAMB_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.REQ[i]) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
            end
        end
`else
        // Search starts just after the owner and wraps, so the owner itself is tried last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, owner_q} + 3'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && idx == 3'(j) && bus.REQ[j]) begin
                    win_found = 1'b1;
                    win_idx   = 2'(j);
                end
            end
        end
`endif
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            owner_q  <= LAST_REQ;
            cnt_q    <= 4'd0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= bus.GNT;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_any = 1'b0;
        gnt_idx = owner_q;
        if (state_q == OWN && req_owner && cnt_q < BURST_CNT) begin
            gnt_any = 1'b1;
            cnt_d   = cnt_q + 4'd1;
        end else if (win_found) begin
            gnt_any = 1'b1;
            gnt_idx = win_idx;
            owner_d = win_idx;
            cnt_d   = 4'd1;
            state_d = OWN;
        end else begin
            // Owner is kept so the next search still rotates from it.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        bus.GNT       = '0;
        bus.RAM_RE    = gnt_any;
        bus.RAM_RADDR = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && gnt_idx == 2'(i)) begin
                bus.GNT[i]    = 1'b1;
                bus.RAM_RADDR = bus.ADDR[i*AW +: AW];
            end
        end
    end

    assign bus.RVALID    = rvalid_q;
    assign bus.RDATA_OUT = bus.RAM_RDATA;
endmodule

// File: tb/tb_ramb_read_arbiter.sv
// tb/tb_ramb_read_arbiter.sv - randomized model-checked bench for ramb_read_arbiter
module tb_ramb_read_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int NA = 2;
    localparam int BA = 4;
    localparam int NB = 4;
    localparam int BB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ramb_read_arbiter_if #(.NREQ(NA), .AW(AW), .DW(DW)) ifa ();
    ramb_read_arbiter_if #(.NREQ(NB), .AW(AW), .DW(DW)) ifb ();

    ramb_read_arbiter #(.NREQ(NA), .AW(AW), .DW(DW), .BURST(BA)) dut_a (.CLKIN(clk), .RESET(rst), .bus(ifa));
    ramb_read_arbiter #(.NREQ(NB), .AW(AW), .DW(DW), .BURST(BB)) dut_b (.CLKIN(clk), .RESET(rst), .bus(ifb));

    function automatic logic [15:0] romv(input logic [10:0] a);
        return 16'({5'b0, a} * 16'h0101);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ifa.RAM_RDATA <= '0;
            ifb.RAM_RDATA <= '0;
        end else begin
            if (ifa.RAM_RE) ifa.RAM_RDATA <= romv(ifa.RAM_RADDR);
            if (ifb.RAM_RE) ifb.RAM_RDATA <= romv(ifb.RAM_RADDR);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int          nreq[2]  = '{NA, NB};
    int          burst[2] = '{BA, BB};
    int          last[2];
    int          run[2];
    int          exp_rv[2];
    logic [10:0] exp_ad[2];
    logic [3:0]  rq[2];
    logic [10:0] ad[2][4];
    int          gnow[2];
    bit          cont[2];
    logic [3:0]  obs_g[2];
    logic [3:0]  obs_rv[2];
    logic [15:0] obs_rd[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last[d]   = nreq[d] - 1;
            run[d]    = 0;
            exp_rv[d] = -1;
            gnow[d]   = -1;
        end
    endtask

    function automatic int pick(input int d);
        if (run[d] > 0 && rq[d][last[d]] && run[d] < burst[d]) return last[d];
`ifdef RAMB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < nreq[d]; k++) if (rq[d][k]) return k;
`else
        for (int k = 1; k <= nreq[d]; k++) begin
            int idx;
            idx = (last[d] + k) % nreq[d];
            if (rq[d][idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic apply();
        ifa.REQ  = rq[0][1:0];
        ifa.ADDR = {ad[0][1], ad[0][0]};
        ifb.REQ  = rq[1];
        ifb.ADDR = {ad[1][3], ad[1][2], ad[1][1], ad[1][0]};
    endtask

    task automatic cycle();
        logic        re;
        logic [10:0] ra;
        logic [3:0]  eg;
        apply();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cont[d] = (run[d] > 0 && rq[d][last[d]] && run[d] < burst[d]);
            gnow[d] = pick(d);
            if (d == 0) begin
                obs_g[d] = {2'b0, ifa.GNT}; re = ifa.RAM_RE; ra = ifa.RAM_RADDR;
                obs_rv[d] = {2'b0, ifa.RVALID}; obs_rd[d] = ifa.RDATA_OUT;
            end else begin
                obs_g[d] = ifb.GNT; re = ifb.RAM_RE; ra = ifb.RAM_RADDR;
                obs_rv[d] = ifb.RVALID; obs_rd[d] = ifb.RDATA_OUT;
            end
            eg = (gnow[d] < 0) ? 4'd0 : 4'(1 << gnow[d]);
            check($sformatf("gnt%0d", d), 32'(obs_g[d]), 32'(eg));
            check($sformatf("ram_re%0d", d), 32'(re), 32'(gnow[d] >= 0));
            check($sformatf("ram_raddr%0d", d), 32'(ra), (gnow[d] < 0) ? 32'd0 : 32'(ad[d][gnow[d]]));
            check($sformatf("rvalid%0d", d), 32'(obs_rv[d]), (exp_rv[d] < 0) ? 32'd0 : 32'(1 << exp_rv[d]));
            if (exp_rv[d] >= 0) check($sformatf("rdata%0d", d), 32'(obs_rd[d]), 32'(romv(exp_ad[d])));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (gnow[d] < 0) run[d] = 0;
            else if (cont[d]) run[d]++;
            else begin
                run[d]  = 1;
                last[d] = gnow[d];
            end
            exp_rv[d] = gnow[d];
            exp_ad[d] = (gnow[d] < 0) ? 11'd0 : ad[d][gnow[d]];
        end
        #1;
    endtask

    task automatic next_rand();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nreq[d]; i++) begin
                if (!rq[d][i] || gnow[d] == i) begin
                    rq[d][i] = ($urandom_range(0, 3) != 0);
                    ad[d][i] = 11'($urandom);
                end
            end
        end
    endtask

`ifdef RAMB_ARB_FIXED_PRIO_EN
    logic [3:0] tbl_a[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] tbl_b[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    logic [3:0] tbl_a[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    logic [3:0] tbl_b[9] = '{1, 2, 4, 8, 1, 2, 4, 8, 1};
`endif

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rq[d] = 4'd0;
            for (int i = 0; i < 4; i++) ad[d][i] = 11'd0;
        end
        model_reset();
        apply();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rvalid_a", 32'(ifa.RVALID), 32'd0);
        check("reset_rvalid_b", 32'(ifb.RVALID), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (10) cycle();

        rq[0] = 4'b0011;
        rq[1] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ad[0][i] = 11'(16 + i);
            ad[1][i] = 11'(32 + i);
        end
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("seq_a", 32'(obs_g[0]), 32'(tbl_a[i]));
            check("seq_b", 32'(obs_g[1]), 32'(tbl_b[i]));
        end

        rq[1] = 4'b1011;
        repeat (6) begin
            cycle();
            check("skip2_b", 32'(obs_g[1][2]), 32'd0);
        end

        rq[0] = 4'd0;
        rq[1] = 4'd0;
        cycle();
        rq[0] = 4'b0001;
        ad[0][0] = 11'd5;
        cycle();
        check("single_gnt", 32'(obs_g[0]), 32'd1);
        rq[0] = 4'd0;
        cycle();
        check("single_rv", 32'(obs_rv[0]), 32'd1);
        check("single_rd", 32'(obs_rd[0]), 32'h0505);

        rq[0] = 4'b0001;
        ad[0][0] = 11'd7;
        cycle();
        check("pre_rst_gnt", 32'(obs_g[0]), 32'd1);
        rst = 1'b1;
        model_reset();
        rq[0] = 4'b0011;
        rq[1] = 4'd0;
        apply();
        @(negedge clk);
        check("mid_rst_rvalid", 32'(ifa.RVALID), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        check("post_rst_rvalid", 32'(obs_rv[0]), 32'd0);
        check("post_rst_gnt", 32'(obs_g[0]), 32'd1);

        for (int n = 0; n < 500; n++) begin
            next_rand();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
